data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder (slave) end of the core's data SRAM interface.
- Answers data_sram_en/wen/addr/wdata requests with a 1-cycle registered data_sram_rdata.
- Backs a byte-writable word RAM and a small memory-mapped config-register window: timer, compare, LED, switch, status.
- Sits at SoC top beside the core; timer_int feeds the core's int[5].

Parameters:
- ADDR_W, 12, log2 of RAM depth in 32-bit words (default 4096 words = 16 KB).
- CONF_HI, 16'hBFAF, value of addr[31:16] that selects the config-register window.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_sram_en  input  1  request valid this cycle.
- data_sram_wen  input  4  byte write enables; 0 = read; bit i = byte lane i.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  write data, lane-aligned.
- data_sram_rdata  output  32  read data, registered.
- switch  input  8  external switch levels, read-only register.
- led  output  16  LED register value.
- timer_int  output  1  level interrupt, equals status pending bit.

Behaviour:
- Reset values (rst=1 at edge): data_sram_rdata=0, led=0, timer=0, compare=0, pending=0, so timer_int=0. RAM contents are not reset.
- Decode: conf_sel = (addr[31:16]==CONF_HI). Otherwise RAM, word index addr[ADDR_W+1:2]; higher address bits ignored, so addresses alias.
- Request cycle N with en=1:
  - data_sram_rdata at N+1 = word at addr before any write in cycle N (read-before-write, also on write cycles).
  - Write lanes with wen[i]=1 are updated at the edge ending N.
- en=0: no access, no write; data_sram_rdata holds its previous value. Any wen with en=0 is ignored.
- Back-to-back requests every cycle are supported; no stall or ready signal exists.
- Config offsets (addr[15:0]):
  - 0x0000 TIMER: RW.
  - 0x0004 COMPARE: RW.
  - 0x0008 LED: RW; bits [15:0] stored, bits [31:16] read 0.
  - 0x000C SWITCH: RO, {24'b0, switch}.
  - 0x0010 STATUS: bit0 = pending; writing 1 to bit0 with wen[0]=1 clears it; other bits read 0.
  - Any other offset reads 0; writes to it are ignored.
- Config writes honour byte enables, merging per lane into the 32-bit register.
- Timer:
  - Every cycle, timer_next = (TIMER write this cycle) ? merged write value : timer+1.
  - Wraps 0xFFFFFFFF -> 0.
  - A write has priority over the increment.
- Pending:
  - Set when timer_next==compare and compare!=0.
  - Cleared by a STATUS write of 1.
  - If set and clear occur in the same cycle, set wins.
  - Sticky otherwise. timer_int = pending (registered).
- A read of TIMER in cycle N returns the timer value held during cycle N, i.e. before that cycle's increment.
- Reset asserted mid-access: registers return to reset values at that edge; the pending read result is discarded (rdata=0); a RAM write presented in the reset cycle is still performed.

Optional Feature:
- Macro CONFREG_TIMER_EN.
- Defined: TIMER, COMPARE and STATUS registers exist and timer_int behaves as above.
- Undefined: offsets 0x0000, 0x0004 and 0x0010 behave as undefined offsets (read 0, writes ignored); timer_int is constant 0; no timer logic is synthesised. LED and SWITCH are unaffected.

Test Plan:
- RAM write then read: write 0x12345678 to 0x00000100 with wen=4'hF; read 0x00000100 next cycle -> rdata=0x12345678 one cycle after the read request.
- Byte lanes and aliasing: with word = 0x12345678, write 0xAABBCCDD with wen=4'b0101 -> read returns 0x12BB56DD. Read 0x00004100 (ADDR_W=12) -> same word.
- Read-before-write and hold: write 0xFFFFFFFF to a word holding 0x00000001 -> rdata next cycle = 0x00000001. Then idle (en=0) 3 cycles -> rdata stays 0x00000001.
- LED and switch:
  - write 0xDEAD1234 to 0xBFAF0008 -> led=16'h1234 after the edge; reading it back returns 0x00001234.
  - switch=8'hA5, read 0xBFAF000C -> 0x000000A5.
  - read 0xBFAF0020 -> 0.
- Timer interrupt (CONFREG_TIMER_EN):
  - write TIMER=0x10, COMPARE=0x14 -> timer_int rises 4 cycles after the TIMER write.
  - write STATUS=1 -> timer_int falls next cycle.
  - TIMER=0xFFFFFFFF wraps to 0 on the next cycle.
- Reset mid-operation: after the timer test, assert rst for one cycle during a read -> rdata=0, led=0, timer_int=0, TIMER reads 0 on the first post-reset access. RAM contents are retained.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the core's data SRAM port, with a byte-writable word RAM
// and a config-register window. Timer/compare/status and timer_int exist only with CONFREG_TIMER_EN.
module data_sram_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_int
);
    localparam int          DEPTH       = 1 << ADDR_W;
    localparam logic [15:0] OFF_TIMER   = 16'h0000;
    localparam logic [15:0] OFF_COMPARE = 16'h0004;
    localparam logic [15:0] OFF_LED     = 16'h0008;
    localparam logic [15:0] OFF_SWITCH  = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    logic [31:0]       mem [DEPTH];
    logic              conf_sel;
    logic [15:0]       conf_off;
    logic [ADDR_W-1:0] word_idx;
    logic              conf_wr;
    logic [31:0]       conf_rd;
    logic [15:0]       led_q;
    logic              unused_addr;

    assign conf_sel    = (data_sram_addr[31:16] == CONF_HI);
    assign conf_off    = data_sram_addr[15:0];
    assign word_idx    = data_sram_addr[ADDR_W+1:2];
    assign conf_wr     = data_sram_en && conf_sel && (data_sram_wen != 4'b0000);
    assign unused_addr = ^data_sram_addr;
    assign led         = led_q;

    // RAM is not reset: a write presented during reset still lands.
    always_ff @(posedge clk) begin
        if (data_sram_en && !conf_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 16'd0;
        end else if (conf_wr && conf_off == OFF_LED) begin
            if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] byte_mask;
    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic [31:0] timer_next;
    logic        pending_q;
    logic        status_clr;

    assign byte_mask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                        {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
    assign status_clr = data_sram_en && conf_sel && conf_off == OFF_STATUS
                        && data_sram_wen[0] && data_sram_wdata[0];

    always_comb begin
        timer_next = timer_q + 32'd1;
        if (conf_wr && conf_off == OFF_TIMER)
            timer_next = (timer_q & ~byte_mask) | (data_sram_wdata & byte_mask);
    end

    // A match on the upcoming timer value beats a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= 32'd0;
            compare_q <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            timer_q <= timer_next;
            if (conf_wr && conf_off == OFF_COMPARE)
                compare_q <= (compare_q & ~byte_mask) | (data_sram_wdata & byte_mask);
            if (timer_next == compare_q && compare_q != 32'd0) pending_q <= 1'b1;
            else if (status_clr)                                pending_q <= 1'b0;
        end
    end

    assign timer_int = pending_q;
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        conf_rd = 32'd0;
        case (conf_off)
`ifdef CONFREG_TIMER_EN
            OFF_TIMER:   conf_rd = timer_q;
            OFF_COMPARE: conf_rd = compare_q;
            OFF_STATUS:  conf_rd = {31'd0, pending_q};
`endif
            OFF_LED:     conf_rd = {16'd0, led_q};
            OFF_SWITCH:  conf_rd = {24'd0, switch};
            default:     conf_rd = 32'd0;
        endcase
    end

    // Read data reflects state before this cycle's write; it holds while idle.
    always_ff @(posedge clk) begin
        if (rst)               data_sram_rdata <= 32'd0;
        else if (data_sram_en) data_sram_rdata <= conf_sel ? conf_rd : mem[word_idx];
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: table vectors, directed multi-cycle sequences and random traffic
// checked against a behavioural model. Timer sequences depend on CONFREG_TIMER_EN.
module tb_data_sram_responder;
  localparam int AW = 12;
`ifdef CONFREG_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        timer_int;

  int total = 0;
  int bad = 0;

  data_sram_responder #(.ADDR_W(AW), .CONF_HI(16'hBFAF)) dut (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .switch(sw), .led(led), .timer_int(timer_int)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // behavioural model state
  logic [31:0] m_mem[int];
  logic [31:0] m_rdata = 32'd0;
  bit          m_known = 1'b0;
  logic [15:0] m_led = 16'd0;
  logic [31:0] m_timer = 32'd0;
  logic [31:0] m_compare = 32'd0;
  bit          m_pend = 1'b0;

  function automatic logic [31:0] lane_mask(input logic [3:0] w);
    logic [31:0] m = 32'd0;
    for (int i = 0; i < 4; i++) if (w[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] conf_read(input logic [15:0] off, input logic [7:0] s);
    case (off)
      16'h0000: return TEN ? m_timer : 32'd0;
      16'h0004: return TEN ? m_compare : 32'd0;
      16'h0008: return {16'd0, m_led};
      16'h000C: return {24'd0, s};
      16'h0010: return TEN ? {31'd0, m_pend} : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    bit          conf = (a[31:16] == 16'hBFAF);
    logic [15:0] off = a[15:0];
    int          idx = int'(a[AW+1:2]);
    logic [31:0] mask = lane_mask(w);
    logic [31:0] rv = 32'd0;
    bit          rk = 1'b1;
    logic [31:0] tnext;
    bit          cwr = e && conf && (w != 4'd0);
    if (conf) rv = conf_read(off, s);
    else if (m_mem.exists(idx)) rv = m_mem[idx];
    else rk = 1'b0;
    if (e && !conf && w != 4'd0) begin
      if (m_mem.exists(idx)) m_mem[idx] = (m_mem[idx] & ~mask) | (d & mask);
      else if (w == 4'hF) m_mem[idx] = d;
    end
    if (r) begin
      m_rdata = 32'd0; m_known = 1'b1; m_led = 16'd0;
      m_timer = 32'd0; m_compare = 32'd0; m_pend = 1'b0;
      return;
    end
    if (e) begin m_rdata = rv; m_known = rk; end
    tnext = m_timer + 32'd1;
    if (TEN && cwr && off == 16'h0000) tnext = (m_timer & ~mask) | (d & mask);
    if (TEN && tnext == m_compare && m_compare != 32'd0) m_pend = 1'b1;
    else if (TEN && e && conf && off == 16'h0010 && w[0] && d[0]) m_pend = 1'b0;
    if (cwr && off == 16'h0008) m_led = ((m_led & ~mask[15:0]) | (d[15:0] & mask[15:0]));
    if (TEN && cwr && off == 16'h0004) m_compare = (m_compare & ~mask) | (d & mask);
    m_timer = tnext;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // driver: present one request, let the edge pass, compare against the model
  task automatic do_cycle(input logic r, input logic e, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    rst = r; en = e; wen = w; addr = a; wdata = d; sw = s;
    @(posedge clk);
    model_step(r, e, w, a, d, s);
    #1;
    if (m_known) check("model_rdata", rdata, m_rdata);
    check("model_led", {16'd0, led}, {16'd0, m_led});
    check("model_timer_int", {31'd0, timer_int}, {31'd0, m_pend});
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 8'h00, 1'b0, 32'h0,         16'h0};
    tbl[1]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         8'h00, 1'b1, 32'h1234_5678, 16'h0};
    tbl[2]  = '{1'b1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 8'h00, 1'b1, 32'h1234_5678, 16'h0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_4100, 32'h0,         8'h00, 1'b1, 32'h12BB_56DD, 16'h0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         8'h00, 1'b1, 32'h12BB_56DD, 16'h0};
    tbl[5]  = '{1'b1, 4'hF, 32'h0000_0104, 32'h0000_0001, 8'h00, 1'b0, 32'h0,         16'h0};
    tbl[6]  = '{1'b1, 4'hF, 32'h0000_0104, 32'hFFFF_FFFF, 8'h00, 1'b1, 32'h0000_0001, 16'h0};
    tbl[7]  = '{1'b0, 4'h0, 32'h0000_0104, 32'h0,         8'h00, 1'b1, 32'h0000_0001, 16'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0000_0104, 32'h0,         8'h00, 1'b1, 32'h0000_0001, 16'h0};
    tbl[9]  = '{1'b0, 4'h0, 32'h0000_0104, 32'h0,         8'h00, 1'b1, 32'h0000_0001, 16'h0};
    tbl[10] = '{1'b1, 4'hF, 32'hBFAF_0008, 32'hDEAD_1234, 8'h00, 1'b1, 32'h0,         16'h1234};
    tbl[11] = '{1'b1, 4'h0, 32'hBFAF_0008, 32'h0,         8'h00, 1'b1, 32'h0000_1234, 16'h1234};
    tbl[12] = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0,         8'hA5, 1'b1, 32'h0000_00A5, 16'h1234};
    tbl[13] = '{1'b1, 4'h0, 32'hBFAF_0020, 32'h0,         8'hA5, 1'b1, 32'h0,         16'h1234};
    tbl[14] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,         8'h00, 1'b1, 32'h0,         16'h1234};
    tbl[15] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         8'h00, 1'b1, 32'h12BB_56DD, 16'h1234};
    tbl[16] = '{1'b1, 4'h2, 32'hBFAF_0008, 32'h0000_AB00, 8'h00, 1'b1, 32'h0000_1234, 16'hAB34};
    tbl[17] = '{1'b1, 4'h0, 32'hBFAF_0008, 32'h0,         8'h00, 1'b1, 32'h0000_AB34, 16'hAB34};

    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h0;
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'd0, led}, 32'h0);
    check("reset_timer_int", {31'd0, timer_int}, 32'h0);

    // table vectors
    for (int i = 0; i < 18; i++) begin
      do_cycle(1'b0, tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].sw);
      if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_led", i), {16'd0, led}, {16'd0, tbl[i].exp_led});
    end

`ifdef CONFREG_TIMER_EN
    // compare match four edges after the TIMER write, then clear and wrap
    do_cycle(1'b0, 1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_0010, 8'h00);
    do_cycle(1'b0, 1'b1, 4'hF, 32'hBFAF_0004, 32'h0000_0014, 8'h00);
    check("irq_low_1", {31'd0, timer_int}, 32'd0);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    check("irq_low_3", {31'd0, timer_int}, 32'd0);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    check("irq_rise_4", {31'd0, timer_int}, 32'd1);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 8'h00);
    check("timer_read", rdata, 32'h0000_0014);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0, 8'h00);
    check("status_read", rdata, 32'h1);
    do_cycle(1'b0, 1'b1, 4'h1, 32'hBFAF_0010, 32'h0000_0001, 8'h00);
    check("irq_cleared", {31'd0, timer_int}, 32'd0);
    do_cycle(1'b0, 1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF, 8'h00);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 8'h00);
    check("timer_max", rdata, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 8'h00);
    check("timer_wrap", rdata, 32'h0);
`else
    // timer window absent: those offsets read 0 and ignore writes
    do_cycle(1'b0, 1'b1, 4'hF, 32'hBFAF_0004, 32'h0000_0014, 8'h00);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0, 8'h00);
    check("compare_absent", rdata, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 8'h00);
    check("timer_absent", rdata, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0, 8'h00);
    check("status_absent", rdata, 32'h0);
`endif

    // reset in the middle of traffic; RAM survives, including a write made during reset
    do_cycle(1'b1, 1'b1, 4'h0, 32'h0000_0100, 32'h0, 8'h00);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_led", {16'd0, led}, 32'h0);
    check("midrst_irq", {31'd0, timer_int}, 32'h0);
    do_cycle(1'b1, 1'b1, 4'hF, 32'h0000_0108, 32'hCAFE_F00D, 8'h00);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0, 8'h00);
    check("postrst_timer", rdata, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0, 8'h00);
    check("postrst_ram", rdata, 32'h12BB_56DD);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0000_0108, 32'h0, 8'h00);
    check("rst_cycle_write", rdata, 32'hCAFE_F00D);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [15:0] off;
      if ($urandom_range(0, 1) == 0) begin
        a = 32'h100 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 14)
            | 32'($urandom_range(0, 3));
        d = $urandom;
      end else begin
        off = 16'($urandom_range(0, 9) * 4);
        a = {16'hBFAF, off};
        if (off == 16'h0000)      d = 32'($urandom_range(0, 30));
        else if (off == 16'h0004) d = 32'($urandom_range(1, 40));
        else                      d = $urandom;
      end
      do_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)), a, d, 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
